// File: rtl/lmc_seq.sv
// lmc_seq -- tiny Little-Man-Computer style sequencer.
// Fetches 8-bit instructions from an external synchronous RAM, executes them
// on a 4-bit accumulator and pushes results out through a valid/ready port.
// Every instruction takes FETCH, DECODE and EXEC cycles; OUT may stall in EXEC.
// Optional feature: define LMC_SEQ_SUB_EN to enable the SUBI opcode (0x3);
// without it opcode 0x3 behaves as a NOP.
// The jump target is operand[ADDR_WIDTH-1:0], so ADDR_WIDTH must be 1..4.

module lmc_seq #(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  timer555,
   input  logic                  reset_count_n,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_rd,
   input  logic [DATA_WIDTH-1:0] ram_data,
   output logic [3:0]            acc_out,
   output logic [ADDR_WIDTH-1:0] pc_out,
   output logic                  carry,
   output logic [3:0]            out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  halted
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_DECODE = 3'd2;
   localparam logic [2:0] ST_EXEC   = 3'd3;
   localparam logic [2:0] ST_HALT   = 3'd4;

   localparam logic [3:0] OP_HLT  = 4'h0;
   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_ADDI = 4'h2;
   localparam logic [3:0] OP_SUBI = 4'h3;
   localparam logic [3:0] OP_JMP  = 4'h4;
   localparam logic [3:0] OP_JZ   = 4'h5;
   localparam logic [3:0] OP_OUT  = 4'h6;

   localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

   logic [2:0]            state;
   logic [ADDR_WIDTH-1:0] pc;
   logic [DATA_WIDTH-1:0] ir;
   logic [3:0]            acc;

   logic [3:0]            opcode;
   logic [3:0]            operand;
   logic [ADDR_WIDTH-1:0] pc_inc;
   logic [ADDR_WIDTH-1:0] jump_target;
   logic [4:0]            add_sum;

   // Instruction fields and the arithmetic shared by several opcodes
   always_comb begin
      opcode      = ir[7:4];
      operand     = ir[3:0];
      pc_inc      = pc + PC_ONE;
      jump_target = operand[ADDR_WIDTH-1:0];
      add_sum     = {1'b0, acc} + {1'b0, operand};
   end

   // Main sequencer: state, PC, IR, accumulator, flag and output-port registers
   always_ff @(posedge timer555) begin
      if (!reset_count_n) begin
         state     <= ST_IDLE;
         pc        <= '0;
         ir        <= '0;
         acc       <= '0;
         carry     <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_HALT: begin
               if (start) begin
                  state <= ST_FETCH;
                  pc    <= '0;
                  acc   <= '0;
                  carry <= 1'b0;
               end
            end
            ST_FETCH: begin
               state <= ST_DECODE;
            end
            ST_DECODE: begin
               ir    <= ram_data;
               state <= ST_EXEC;
               if (ram_data[7:4] == OP_OUT) begin
                  out_data  <= acc;
                  out_valid <= 1'b1;
               end
            end
            ST_EXEC: begin
               case (opcode)
                  OP_HLT: begin
                     state <= ST_HALT;
                  end
                  OP_LDI: begin
                     acc   <= operand;
                     pc    <= pc_inc;
                     state <= ST_FETCH;
                  end
                  OP_ADDI: begin
                     {carry, acc} <= add_sum;
                     pc           <= pc_inc;
                     state        <= ST_FETCH;
                  end
`ifdef LMC_SEQ_SUB_EN
                  OP_SUBI: begin
                     acc   <= acc - operand;
                     carry <= (operand > acc);
                     pc    <= pc_inc;
                     state <= ST_FETCH;
                  end
`else
                  OP_SUBI: begin
                     pc    <= pc_inc;
                     state <= ST_FETCH;
                  end
`endif
                  OP_JMP: begin
                     pc    <= jump_target;
                     state <= ST_FETCH;
                  end
                  OP_JZ: begin
                     pc    <= (acc == 4'h0) ? jump_target : pc_inc;
                     state <= ST_FETCH;
                  end
                  OP_OUT: begin
                     if (out_ready) begin
                        out_valid <= 1'b0;
                        pc        <= pc_inc;
                        state     <= ST_FETCH;
                     end
                  end
                  default: begin
                     pc    <= pc_inc;
                     state <= ST_FETCH;
                  end
               endcase
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Status and RAM strobes decoded straight from the state register
   always_comb begin
      ram_rd   = (state == ST_FETCH);
      ram_addr = pc;
      busy     = (state == ST_FETCH) || (state == ST_DECODE) || (state == ST_EXEC);
      halted   = (state == ST_HALT);
      acc_out  = acc;
      pc_out   = pc;
   end

endmodule

// File: tb/tb_lmc_seq.sv
// tb_lmc_seq -- self-checking bench for lmc_seq.
// Runs directed programs and random programs against an instruction-level
// reference model of the machine; the RAM is a synchronous-read array.

module tb_lmc_seq;

   logic       timer555 = 1'b0;
   logic       reset_count_n = 1'b0;
   logic       start = 1'b0;
   logic       out_ready = 1'b0;
   logic [1:0] ram_addr;
   logic       ram_rd;
   logic [7:0] ram_data = 8'h00;
   logic [3:0] acc_out;
   logic [1:0] pc_out;
   logic       carry;
   logic [3:0] out_data;
   logic       out_valid;
   logic       busy;
   logic       halted;

   logic [7:0] mem [4];
   logic       rd_q = 1'b0;
   logic [1:0] addr_q = 2'd0;

   int compared = 0;
   int mismatched = 0;
   int m_out = 0;

   lmc_seq #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) dut (
      .timer555      (timer555),
      .reset_count_n (reset_count_n),
      .start         (start),
      .ram_addr      (ram_addr),
      .ram_rd        (ram_rd),
      .ram_data      (ram_data),
      .acc_out       (acc_out),
      .pc_out        (pc_out),
      .carry         (carry),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .busy          (busy),
      .halted        (halted)
   );

   // Free-running clock
   always #5 timer555 = ~timer555;

   // Capture the read request mid-cycle so the RAM model never races the DUT
   always @(negedge timer555) begin
      rd_q   <= ram_rd;
      addr_q <= ram_addr;
   end

   // Synchronous RAM: data appears one cycle after the read strobe
   always @(posedge timer555) begin
      if (rd_q) ram_data <= mem[addr_q];
   end

   // Give up if something stalls far beyond any legal run length
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge timer555);
      #1;
   endtask

   task automatic checkOutput(input string tag, input int observed, input int expected);
      compared++;
      if (observed != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic loadProgram(input logic [31:0] prog);
      for (int i = 0; i < 4; i++) mem[i] = prog[8*i +: 8];
   endtask

   // Reset for one edge and confirm every output is at its cleared value
   task automatic doReset();
      reset_count_n = 1'b0;
      start = 1'b0;
      tick();
      reset_count_n = 1'b1;
      m_out = 0;
      checkOutput("rst_pc", int'(pc_out), 0);
      checkOutput("rst_acc", int'(acc_out), 0);
      checkOutput("rst_carry", int'(carry), 0);
      checkOutput("rst_out_data", int'(out_data), 0);
      checkOutput("rst_out_valid", int'(out_valid), 0);
      checkOutput("rst_ram_rd", int'(ram_rd), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_halted", int'(halted), 0);
   endtask

   // Start the loaded program and check it instruction by instruction against
   // an ISA-level model; stall < 0 means random OUT back-pressure
   task automatic applyStimulus(input logic [31:0] prog, input int max_instr, input int stall,
                                output int cycles, output int valid_cycles, output int hm);
      int m_pc;
      int m_acc;
      int m_carry;
      loadProgram(prog);
      cycles = 0;
      valid_cycles = 0;
      hm = 0;
      m_pc = 0;
      m_acc = 0;
      m_carry = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 0; n < max_instr && hm == 0; n++) begin
         int instr;
         int op;
         int opnd;
         int s;
         instr = int'(mem[m_pc]);
         op = instr / 16;
         opnd = instr % 16;
         checkOutput("fetch_rd", int'(ram_rd), 1);
         checkOutput("fetch_addr", int'(ram_addr), m_pc);
         checkOutput("fetch_busy", int'(busy), 1);
         if ($urandom_range(0, 3) == 0) start = 1'b1;
         tick();
         cycles++;
         start = 1'b0;
         checkOutput("decode_rd", int'(ram_rd), 0);
         tick();
         cycles++;
         if (op == 6) begin
            s = (stall >= 0) ? stall : int'($urandom_range(0, 3));
            for (int k = 0; k <= s; k++) begin
               checkOutput("out_valid_hi", int'(out_valid), 1);
               checkOutput("out_data_val", int'(out_data), m_acc);
               checkOutput("out_pc_hold", int'(pc_out), m_pc);
               out_ready = (k == s);
               tick();
               cycles++;
               valid_cycles++;
            end
            out_ready = 1'b0;
         end else begin
            out_ready = $urandom_range(0, 1) == 1;
            tick();
            cycles++;
            out_ready = 1'b0;
         end
         if (op == 0) begin
            hm = 1;
         end else if (op == 1) begin
            m_acc = opnd;
            m_pc = (m_pc + 1) % 4;
         end else if (op == 2) begin
            s = m_acc + opnd;
            m_acc = s % 16;
            m_carry = s / 16;
            m_pc = (m_pc + 1) % 4;
         end else if (op == 4) begin
            m_pc = opnd % 4;
         end else if (op == 5) begin
            m_pc = (m_acc == 0) ? opnd % 4 : (m_pc + 1) % 4;
         end else begin
`ifdef LMC_SEQ_SUB_EN
            if (op == 3) begin
               m_carry = (opnd > m_acc) ? 1 : 0;
               m_acc = (m_acc - opnd + 16) % 16;
            end
`endif
            if (op == 6) m_out = m_acc;
            m_pc = (m_pc + 1) % 4;
         end
         checkOutput("acc", int'(acc_out), m_acc);
         checkOutput("carry", int'(carry), m_carry);
         checkOutput("pc", int'(pc_out), m_pc);
         checkOutput("out_data_hold", int'(out_data), m_out);
         checkOutput("out_valid_lo", int'(out_valid), 0);
         checkOutput("halted", int'(halted), hm);
         checkOutput("busy", int'(busy), 1 - hm);
      end
   endtask

   initial begin
      int cyc;
      int vc;
      int hm;

      doReset();

      // LDI 5, ADDI 12, OUT, HLT: overflow into carry, 12 cycles to halt
      applyStimulus(32'h00602C15, 10, 0, cyc, vc, hm);
      checkOutput("d030_halted", hm, 1);
      checkOutput("d030_cycles", cyc, 12);
      checkOutput("d030_out_data", int'(out_data), 1);
      checkOutput("d030_carry", int'(carry), 1);
      checkOutput("d030_pc", int'(pc_out), 3);

      // OUT held back by five not-ready cycles
      applyStimulus(32'h00006013, 10, 5, cyc, vc, hm);
      checkOutput("d031_valid_cycles", vc, 6);
      checkOutput("d031_out_data", int'(out_data), 3);

      // JZ taken over the LDI 0xF
      applyStimulus(32'h001F5310, 10, -1, cyc, vc, hm);
      checkOutput("d032_acc", int'(acc_out), 0);
      checkOutput("d032_pc", int'(pc_out), 3);
      checkOutput("d032_halted", int'(halted), 1);

      // NOP/ADDI/NOP/JMP loop that never halts
      applyStimulus(32'h407F2F72, 2, -1, cyc, vc, hm);
      checkOutput("d033_acc", int'(acc_out), 15);
      checkOutput("d033_carry", int'(carry), 0);
      doReset();
      applyStimulus(32'h407F2F72, 9, -1, cyc, vc, hm);
      checkOutput("d033_never_halts", hm + int'(halted), 0);
      doReset();

      // SUBI with borrow, or NOP when the feature is absent
      applyStimulus(32'h00003512, 10, -1, cyc, vc, hm);
`ifdef LMC_SEQ_SUB_EN
      checkOutput("d034_acc", int'(acc_out), 13);
      checkOutput("d034_carry", int'(carry), 1);
`else
      checkOutput("d034_acc", int'(acc_out), 2);
      checkOutput("d034_carry", int'(carry), 0);
`endif

      // Reset landing on a DECODE cycle, then a clean rerun
      loadProgram(32'h00602C15);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      checkOutput("d035_in_decode", int'(busy) * 2 + int'(ram_rd), 2);
      doReset();
      applyStimulus(32'h00602C15, 10, 0, cyc, vc, hm);
      checkOutput("d035_rerun_cycles", cyc, 12);

      // Reset landing on a stalled OUT while ready rises: no transfer
      loadProgram(32'h00006013);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      checkOutput("d035_stalled_valid", int'(out_valid), 1);
      out_ready = 1'b1;
      doReset();
      out_ready = 1'b0;
      applyStimulus(32'h00006013, 10, 2, cyc, vc, hm);
      checkOutput("d035_rerun_out", int'(out_data), 3);

      // Random programs with meaningful opcodes and random back-pressure
      for (int p = 0; p < 25; p++) begin
         logic [31:0] prog;
         for (int b = 0; b < 4; b++) begin
            prog[8*b +: 8] = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
         end
         applyStimulus(prog, 10, -1, cyc, vc, hm);
         if (hm == 0) doReset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
